axon_event_dispatch: RTL and testbench
======================================

// Module: axon_event_dispatch
// PURPOSE
// - Sits directly downstream of the scheduler and consumes its per-tick axon event packets (PKT_SIZE-GRANULARITY bits).
// - Per event: reads the crossbar row for the axon and walks it, issuing one INTEGRATE command per connected neuron.
// - Per tick: after the in-flight event, sweeps all neurons with UPDATE (leak/threshold/fire) commands.
// PARAMETERS
// - N_COUNT      256  neurons in the core (= crossbar row width)
// - N_AXONS      256  axons in the core (= crossbar rows)
// - GRANULARITY  4    scheduler tick slots; sets event width
// - PKT_SIZE     32   router packet width; EVT_W = PKT_SIZE-GRANULARITY (localparam)
// PORTS
// - clk            in   1        core clock
// - rst_n          in   1        asynchronous, active-low reset
// - tick           in   1        global tick, single-cycle strobe synchronous to clk
// - evt_data       in   EVT_W    [AXON_W-1:0]=axon id, [AXON_W+1:AXON_W]=axon type, rest ignored
// - evt_valid      in   1        scheduler has an event
// - evt_ready      out  1        block accepts event this cycle
// - xbar_rd_en     out  1        crossbar SRAM read strobe
// - xbar_rd_addr   out  AXON_W   crossbar row address (= latched axon id)
// - xbar_rd_data   in   N_COUNT  row data, valid the cycle after xbar_rd_en
// - cmd_valid      out  1        neuron command valid
// - cmd_ready      in   1        neuron unit accepts command
// - cmd_op         out  2        00 NOP, 01 INTEGRATE, 10 UPDATE
// - cmd_neuron     out  NIDX_W   target neuron, NIDX_W=$clog2(N_COUNT)
// - cmd_axon_type  out  2        axon type for INTEGRATE; 0 for UPDATE
// - busy           out  1        state != IDLE or tick pending
// - tick_overrun   out  1        1-cycle pulse: tick arrived while one already pending
// BEHAVIOUR
// - Reset: state=IDLE, idx=0, row=0, tick_pending=0; all outputs 0 (evt_ready=1 after release).
// - States: IDLE -> FETCH -> LOAD -> SCAN -> IDLE|SWEEP; IDLE -> SWEEP if tick_pending; SWEEP -> IDLE|SWEEP.
// - evt_ready = (state==IDLE) & ~tick_pending & ~tick; tick wins over a same-cycle event.
// - Accept (evt_valid&evt_ready): latch axon id/type, go FETCH.
// - FETCH: xbar_rd_en=1, xbar_rd_addr=axon id. LOAD: capture xbar_rd_data into row reg, idx=0.
// - SCAN, per idx: row[idx]=0 -> no cmd, idx++ next cycle; row[idx]=1 -> cmd_valid=1, INTEGRATE, cmd_neuron=idx,
//   held stable until cmd_valid&cmd_ready, then idx++. Leave SCAN after idx=N_COUNT-1 completes.
// - Latency (cmd_ready=1): accept cycle 0, FETCH 1, LOAD 2, SCAN 3..N_COUNT+2, evt_ready again cycle N_COUNT+3.
//   Independent of row content; all-zero row emits nothing, same latency.
// - SWEEP: tick_pending cleared on entry; idx 0..N_COUNT-1, cmd_valid=1 every cycle, UPDATE, advance on handshake.
// - tick: sets tick_pending in any state; if already pending -> tick_overrun pulse, ticks merge (one sweep).
//   tick during SWEEP with pending clear -> pending set, second sweep follows immediately.
// - After SCAN: SWEEP if tick_pending else IDLE. Events never interleave with a sweep.
// - idx counter NIDX_W bits; terminal compare on N_COUNT-1, no wrap reliance (N_COUNT need not be pow2).
// - cmd_* outputs 0 whenever cmd_valid=0. No command dropped or duplicated under any cmd_ready pattern.
// - rst_n asserted mid-op: immediate return to reset values; in-flight event and pending tick discarded.
// STRUCTURE
// - Shared package snn_pkg: cmd_op_t enum (NOP/INTEGRATE/UPDATE), disp_state_t enum, evt field offset/width constants.
// - Single module: FSM + idx counter + row register inline; no sub-module.
// TESTING (N_COUNT=8, N_AXONS=16)
// - Reset: rst_n low mid-stream -> all outputs 0; 1 cycle after release evt_ready=1, busy=0.
// - Event axon 5 type 2, row 8'b1000_0101, cmd_ready=1 -> xbar_rd_addr=5 at cycle 1; INTEGRATE type 2 to
//   neurons 0,2,7 at cycles 3,5,10; evt_ready=1 at cycle 11.
// - Backpressure: same event, cmd_ready=0 for 4 cycles at neuron 2 -> cmd held stable, then neuron 7; none skipped.
// - Tick at cycle 4 of a scan -> scan completes, then 8 UPDATE cmds neurons 0..7; evt_ready=0 throughout.
// - Tick and evt_valid same cycle in IDLE -> event not accepted, sweep first, then event accepted.
// - Two ticks during one scan -> tick_overrun pulses once, exactly one sweep; all-zero row -> no cmds, evt_ready at 11.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg: shared types and constants for the axon event dispatcher.
// Provides the neuron command opcodes, the dispatcher FSM states and the
// field layout of a scheduler event word (axon id in the low bits, followed
// by a 2-bit axon type).
package snn_pkg;

    typedef enum logic [1:0] {
        CMD_NOP       = 2'b00,
        CMD_INTEGRATE = 2'b01,
        CMD_UPDATE    = 2'b10
    } cmd_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_SWEEP = 3'd4
    } disp_state_t;

    localparam int EVT_AXON_LSB = 0;
    localparam int EVT_TYPE_W   = 2;

endpackage

// File: rtl/axon_event_dispatch.sv
// axon_event_dispatch: turns scheduler axon events into neuron commands.
// Each accepted event fetches its crossbar row and issues one INTEGRATE per
// connected neuron; each tick triggers a full UPDATE sweep once no event is
// in flight.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   tick                            single-cycle global tick strobe
//   evt_data/evt_valid/evt_ready    scheduler event handshake
//   xbar_rd_en/addr/data            crossbar row read (data one cycle after en)
//   cmd_valid/ready/op/neuron/axon_type  neuron command handshake
//   busy, tick_overrun              status
module axon_event_dispatch
    import snn_pkg::*;
#(
    parameter int N_COUNT     = 256,
    parameter int N_AXONS     = 256,
    parameter int GRANULARITY = 4,
    parameter int PKT_SIZE    = 32,
    localparam int EVT_W      = PKT_SIZE - GRANULARITY,
    localparam int AXON_W     = $clog2(N_AXONS),
    localparam int NIDX_W     = $clog2(N_COUNT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [EVT_W-1:0]   evt_data,
    input  logic               evt_valid,
    output logic               evt_ready,
    output logic               xbar_rd_en,
    output logic [AXON_W-1:0]  xbar_rd_addr,
    input  logic [N_COUNT-1:0] xbar_rd_data,
    output logic               cmd_valid,
    input  logic               cmd_ready,
    output logic [1:0]         cmd_op,
    output logic [NIDX_W-1:0]  cmd_neuron,
    output logic [1:0]         cmd_axon_type,
    output logic               busy,
    output logic               tick_overrun
);

    disp_state_t             state;
    logic [NIDX_W-1:0]       idx;
    logic [N_COUNT-1:0]      row;
    logic [AXON_W-1:0]       axon_id;
    logic [EVT_TYPE_W-1:0]   axon_type;
    logic                    tick_pending;
    logic                    run;
    logic                    accept;
    logic                    last;
    logic                    adv;
    logic                    to_sweep;
    logic                    evt_unused;

    assign evt_unused = ^evt_data[EVT_W-1:AXON_W+EVT_TYPE_W];

    // run keeps evt_ready low while reset is held and for the release edge.
    assign evt_ready = run && state == ST_IDLE && !tick_pending && !tick;
    assign accept    = evt_valid && evt_ready;
    assign last      = idx == NIDX_W'(N_COUNT - 1);
    assign cmd_valid = (state == ST_SCAN && row[idx]) || state == ST_SWEEP;
    // Unconnected neurons in a row are skipped without waiting for cmd_ready.
    assign adv       = state == ST_SWEEP ? cmd_ready : (!row[idx] || cmd_ready);
    assign to_sweep  = tick_pending &&
                       (state == ST_IDLE ||
                        ((state == ST_SCAN || state == ST_SWEEP) && last && adv));

    assign cmd_op        = !cmd_valid ? CMD_NOP : state == ST_SWEEP ? CMD_UPDATE : CMD_INTEGRATE;
    assign cmd_neuron    = cmd_valid ? idx : '0;
    assign cmd_axon_type = (cmd_valid && state == ST_SCAN) ? axon_type : '0;
    assign xbar_rd_en    = state == ST_FETCH;
    assign xbar_rd_addr  = axon_id;
    assign busy          = state != ST_IDLE || tick_pending;
    assign tick_overrun  = tick && tick_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            row          <= '0;
            axon_id      <= '0;
            axon_type    <= '0;
            tick_pending <= 1'b0;
            run          <= 1'b0;
        end else begin
            run          <= 1'b1;
            // A tick landing on the sweep-entry cycle stays pending for another sweep.
            tick_pending <= tick || (tick_pending && !to_sweep);
            if (to_sweep) begin
                state <= ST_SWEEP;
                idx   <= '0;
            end else begin
                case (state)
                    ST_IDLE: if (accept) begin
                        axon_id   <= evt_data[EVT_AXON_LSB +: AXON_W];
                        axon_type <= evt_data[AXON_W +: EVT_TYPE_W];
                        state     <= ST_FETCH;
                    end
                    ST_FETCH: state <= ST_LOAD;
                    ST_LOAD: begin
                        row   <= xbar_rd_data;
                        idx   <= '0;
                        state <= ST_SCAN;
                    end
                    ST_SCAN, ST_SWEEP: if (adv) begin
                        if (last) begin
                            state <= ST_IDLE;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axon_event_dispatch.sv
// tb_axon_event_dispatch: directed and randomized checks of the dispatcher.
module tb_axon_event_dispatch;
    import snn_pkg::*;

    localparam int N     = 8;
    localparam int NA    = 16;
    localparam int EVT_W = 28;

    typedef struct packed {
        logic [1:0] op;
        logic [2:0] n;
        logic [1:0] t;
    } cmd_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tick = 1'b0;
    logic [EVT_W-1:0] evt_data = '0;
    logic             evt_valid = 1'b0;
    logic             evt_ready;
    logic             xbar_rd_en;
    logic [3:0]       xbar_rd_addr;
    logic [N-1:0]     xbar_rd_data = '0;
    logic             cmd_valid;
    logic             cmd_ready = 1'b1;
    logic [1:0]       cmd_op;
    logic [2:0]       cmd_neuron;
    logic [1:0]       cmd_axon_type;
    logic             busy;
    logic             tick_overrun;

    logic [N-1:0] mem [NA];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_ovr = 0;
    int   cyc = 0;
    bit   rnd_ready = 0;
    bit   hold = 0;
    logic [6:0] prev_cmd = '0;
    cmd_t got[$];
    int   got_cyc[$];
    cmd_t exp_q[$];

    axon_event_dispatch #(.N_COUNT(N), .N_AXONS(NA), .GRANULARITY(4), .PKT_SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .evt_data(evt_data), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .xbar_rd_en(xbar_rd_en), .xbar_rd_addr(xbar_rd_addr),
        .xbar_rd_data(xbar_rd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_neuron(cmd_neuron), .cmd_axon_type(cmd_axon_type),
        .busy(busy), .tick_overrun(tick_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Crossbar SRAM: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) xbar_rd_data <= xbar_rd_en ? mem[xbar_rd_addr] : N'($urandom);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) begin
                got.push_back({cmd_op, cmd_neuron, cmd_axon_type});
                got_cyc.push_back(cyc);
            end
            if (!cmd_valid) check("cmd_zero", 32'({cmd_op, cmd_neuron, cmd_axon_type}), 0);
            if (hold) check("cmd_hold", 32'({cmd_valid, cmd_op, cmd_neuron, cmd_axon_type}), 32'({1'b1, prev_cmd}));
            if (tick_overrun) n_ovr++;
            hold = cmd_valid && !cmd_ready;
            prev_cmd = {cmd_op, cmd_neuron, cmd_axon_type};
        end else begin
            hold = 0;
        end
    end

    task automatic adv();
        @(posedge clk);
        #1;
        if (rnd_ready) cmd_ready = $urandom_range(0, 3) != 0;
    endtask

    task automatic wait_accept(output int c0);
        bit done = 0;
        c0 = -1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (evt_ready) begin
                c0 = cyc;
                done = 1;
            end
            adv();
        end
        evt_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $error("FAIL accept_timeout: observed no evt_ready expected evt_ready within 300 cycles");
        end
    endtask

    task automatic send_evt(input logic [3:0] a, input logic [1:0] t, output int c0);
        evt_data = EVT_W'({$urandom} << 6) | EVT_W'({t, a});
        evt_valid = 1'b1;
        wait_accept(c0);
    endtask

    task automatic wait_idle(output int c);
        bit done = 0;
        c = -1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (evt_ready) begin
                c = cyc;
                done = 1;
            end
            adv();
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $error("FAIL idle_timeout: observed no evt_ready expected evt_ready within 300 cycles");
        end
    endtask

    task automatic push_int(input logic [N-1:0] r, input logic [1:0] t);
        for (int i = 0; i < N; i++) if (r[i]) exp_q.push_back('{CMD_INTEGRATE, 3'(i), t});
    endtask

    task automatic push_sweep();
        for (int i = 0; i < N; i++) exp_q.push_back('{CMD_UPDATE, 3'(i), 2'b00});
    endtask

    task automatic cmp_cmds(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) check(tag, 32'(got[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_q();
        got.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    function automatic logic [15:0] all_outs();
        return {evt_ready, xbar_rd_en, xbar_rd_addr, cmd_valid, cmd_op, cmd_neuron,
                cmd_axon_type, busy, tick_overrun};
    endfunction

    initial begin
        int c0, c1, tk_at;
        int exp_c[$];
        logic [3:0] a;
        logic [1:0] t;
        bit tk;
        for (int i = 0; i < NA; i++) mem[i] = N'($urandom);
        mem[5] = 8'b1000_0101;
        mem[0] = 8'h00;
        mem[7] = 8'hFF;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 32'(all_outs()), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        adv();
        @(negedge clk);
        check("release_ready", 32'({evt_ready, busy}), 32'(2'b10));
        adv();

        // Event axon 5 type 2, full-rate
        clear_q();
        send_evt(4'd5, 2'd2, c0);
        @(negedge clk);
        check("fetch", 32'({xbar_rd_en, xbar_rd_addr}), 32'({1'b1, 4'd5}));
        adv();
        wait_idle(c1);
        check("evt_latency", c1 - c0, N + 3);
        push_int(mem[5], 2'd2);
        cmp_cmds("evt5");
        for (int i = 0; i < N; i++) if (mem[5][i]) exp_c.push_back(3 + i);
        for (int i = 0; i < exp_c.size() && i < got_cyc.size(); i++) check("evt5_cyc", got_cyc[i] - c0, exp_c[i]);

        // Backpressure on neuron 2 for four cycles
        clear_q();
        send_evt(4'd5, 2'd2, c0);
        repeat (4) adv();
        cmd_ready = 1'b0;
        @(negedge clk);
        check("bp_held", 32'({cmd_valid, cmd_op, cmd_neuron, cmd_axon_type}), 32'({1'b1, CMD_INTEGRATE, 3'd2, 2'd2}));
        repeat (4) adv();
        cmd_ready = 1'b1;
        wait_idle(c1);
        check("bp_latency", c1 - c0, N + 3 + 4);
        push_int(mem[5], 2'd2);
        cmp_cmds("bp");
        if (got_cyc.size() == 3) check("bp_n7_cyc", got_cyc[2] - c0, 3 + 7 + 4);

        // Tick during a scan: scan finishes, then one sweep
        clear_q();
        send_evt(4'd3, 2'd1, c0);
        repeat (3) adv();
        tick = 1'b1;
        adv();
        tick = 1'b0;
        wait_idle(c1);
        check("tick_scan_latency", c1 - c0, 3 + 2 * N);
        push_int(mem[3], 2'd1);
        push_sweep();
        cmp_cmds("tick_scan");

        // Tick and event in the same idle cycle: tick wins
        clear_q();
        tick = 1'b1;
        evt_data = EVT_W'({2'd1, 4'd9});
        evt_valid = 1'b1;
        @(negedge clk);
        check("tick_wins", 32'(evt_ready), 0);
        adv();
        tick = 1'b0;
        wait_accept(c0);
        wait_idle(c1);
        push_sweep();
        push_int(mem[9], 2'd1);
        cmp_cmds("tick_first");

        // Two ticks during one scan merge into one sweep
        clear_q();
        n_ovr = 0;
        send_evt(4'd5, 2'd3, c0);
        repeat (3) adv();
        tick = 1'b1;
        adv();
        tick = 1'b0;
        adv();
        tick = 1'b1;
        adv();
        tick = 1'b0;
        wait_idle(c1);
        check("overrun_pulses", n_ovr, 1);
        check("merge_latency", c1 - c0, 3 + 2 * N);
        push_int(mem[5], 2'd3);
        push_sweep();
        cmp_cmds("merge");

        // All-zero row: no commands, same latency
        clear_q();
        send_evt(4'd0, 2'd1, c0);
        wait_idle(c1);
        check("zero_latency", c1 - c0, N + 3);
        cmp_cmds("zero_row");

        // Reset in mid-scan with a tick pending
        send_evt(4'd7, 2'd1, c0);
        repeat (2) adv();
        tick = 1'b1;
        adv();
        tick = 1'b0;
        adv();
        rst_n = 1'b0;
        #1;
        check("midrst_outs", 32'(all_outs()), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clear_q();
        adv();
        @(negedge clk);
        check("midrst_release", 32'({evt_ready, busy}), 32'(2'b10));
        repeat (12) adv();
        cmp_cmds("midrst_quiet");

        // Randomized events, random backpressure, occasional same-cycle tick
        rnd_ready = 1;
        for (int k = 0; k < 20; k++) begin
            clear_q();
            a = 4'($urandom);
            t = 2'($urandom);
            tk = $urandom_range(0, 2) == 0;
            if (tk) begin
                tick = 1'b1;
                evt_data = EVT_W'({t, a});
                evt_valid = 1'b1;
                adv();
                tick = 1'b0;
                wait_accept(c0);
                push_sweep();
            end else begin
                send_evt(a, t, c0);
            end
            wait_idle(c1);
            push_int(mem[a], t);
            cmp_cmds("rand");
        end
        rnd_ready = 0;
        cmd_ready = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
